// File: rtl/csa_pkg.sv
// csa_pkg: shared state encoding and resolve-stage sizing helpers for the CSA accumulator
package csa_pkg;
    typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} csa_state_t;
    function automatic int num_chunks(input int w, input int chunk);
        return w / chunk;
    endfunction
    function automatic int idx_width(input int w, input int chunk);
        return (w / chunk > 1) ? $clog2(w / chunk) : 1;
    endfunction
endpackage

// File: rtl/csa_3to2.sv
// csa_3to2: one W-bit carry-save level; the carry out of bit W-1 leaves on c_out
module csa_3to2 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] d,
    output logic [W-1:0] s,
    output logic [W-1:0] c,
    output logic         c_out
);
    logic [W-1:0] maj;
    assign s     = a ^ b ^ d;
    assign maj   = (a & b) | (a & d) | (b & d);
    assign c     = {maj[W-2:0], 1'b0};
    assign c_out = maj[W-1];
endmodule

// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: carry-save frame accumulator with chunked carry-propagate resolve
module csa_stream_accumulator
    import csa_pkg::*;
#(
    parameter int N     = 8,
    parameter int K     = 4,
    parameter int W     = 16,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K*N-1:0] in_data,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_sum,
    output logic           out_ovf
);
    localparam int R  = num_chunks(W, CHUNK);
    localparam int IW = idx_width(W, CHUNK);

    if (W % CHUNK != 0) begin : g_bad_chunk
        $error("W must be a multiple of CHUNK");
    end
    if (W <= N) begin : g_bad_width
        $error("W must exceed N");
    end

    csa_state_t     state, state_n;
    logic [W-1:0]   s_q, c_q, res;
    logic           ovf_q, cin;
    logic [IW-1:0]  idx;
    logic [W-1:0]   s_l [K+1];
    logic [W-1:0]   c_l [K+1];
    logic [K-1:0]   co;
    logic [CHUNK:0] csum;
    logic           last_chunk;

    assign s_l[0] = s_q;
    assign c_l[0] = c_q;

    for (genvar g = 0; g < K; g++) begin : g_lvl
        csa_3to2 #(.W(W)) u_lvl (
            .a     (s_l[g]),
            .b     (c_l[g]),
            .d     (W'(in_data[g*N +: N])),
            .s     (s_l[g+1]),
            .c     (c_l[g+1]),
            .c_out (co[g])
        );
    end

    assign csum       = {1'b0, s_q[idx*CHUNK +: CHUNK]} + {1'b0, c_q[idx*CHUNK +: CHUNK]} + (CHUNK+1)'(cin);
    assign last_chunk = idx == IW'(R - 1);
    assign in_ready   = state == ACCUM;
    assign out_valid  = state == OUTPUT;
    assign out_sum    = res;
    assign out_ovf    = ovf_q;

    always_comb begin
        state_n = (state == ACCUM && in_valid && in_last) ? RESOLVE :
                  (state == RESOLVE && last_chunk)        ? OUTPUT  :
                  (state == OUTPUT && out_ready)          ? ACCUM   : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q   <= '0;
            c_q   <= '0;
            res   <= '0;
            ovf_q <= 1'b0;
            cin   <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    idx <= '0;
                    cin <= 1'b0;
                    if (in_valid) begin
                        s_q   <= s_l[K];
                        c_q   <= c_l[K];
                        ovf_q <= ovf_q | (|co);
                    end
                end
                RESOLVE: begin
                    res[idx*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
                    cin                     <= csum[CHUNK];
                    idx                     <= idx + 1'b1;
                    if (last_chunk) ovf_q <= ovf_q | csum[CHUNK];
                end
                OUTPUT: begin
                    if (out_ready) begin
                        s_q   <= '0;
                        c_q   <= '0;
                        res   <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb_csa_stream_accumulator: directed and random frames checked against an integer-sum model
module tb_csa_stream_accumulator;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [15:0] out_sum;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;
    logic [31:0] frame_q [$];
    logic [15:0] b2b_sum;

    csa_stream_accumulator #(.N(8), .K(4), .W(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input int gap, input int hold, output logic [15:0] got);
        longint total = 0;
        int lat = 0;
        logic [15:0] want;
        foreach (frame_q[i]) begin
            int g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int k = 0; k < g; k++) tick();
            for (int j = 0; j < 4; j++) total += frame_q[i][j*8 +: 8];
            check({tag, " in_ready"}, in_ready, 1);
            in_valid = 1;
            in_data  = frame_q[i];
            in_last  = (i == frame_q.size() - 1);
            tick();
            in_valid = 0;
            in_last  = 0;
            in_data  = $urandom;
        end
        want = total[15:0];
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " sum"}, out_sum, want);
        check({tag, " ovf"}, out_ovf, total >= 65536);
        check({tag, " busy"}, in_ready, 0);
        got = out_sum;
        for (int k = 0; k < hold; k++) begin
            tick();
            check({tag, " hold valid"}, out_valid, 1);
            check({tag, " hold sum"}, out_sum, want);
            check({tag, " hold ready"}, in_ready, 0);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        check({tag, " post valid"}, out_valid, 0);
        check({tag, " post ready"}, in_ready, 1);
        check({tag, " post sum"}, out_sum, 0);
    endtask

    initial begin
        logic [15:0] got;
        #12;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_sum", out_sum, 0);
        check("reset out_ovf", out_ovf, 0);
        rst = 0;
        tick();

        frame_q = '{32'h04030201};
        run_frame("t1", 0, 0, got);

        frame_q = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        run_frame("t2", 0, 0, got);
        check("t2 const", got, 16'h0BF4);

        frame_q.delete();
        for (int i = 0; i < 257; i++) frame_q.push_back(32'hFFFFFFFF);
        run_frame("t3", 0, 0, got);
        check("t3 const", got, 16'hFFFC);

        frame_q = '{32'h00000007};
        run_frame("t4", 0, 5, got);
        check("t4 const", got, 16'h0007);

        in_valid = 1;
        in_data  = 32'h01010101;
        in_last  = 1;
        tick();
        in_valid = 0;
        in_last  = 0;
        tick();
        tick();
        rst = 1;
        #1;
        check("t5 rst valid", out_valid, 0);
        check("t5 rst ready", in_ready, 1);
        tick();
        rst = 0;
        tick();
        frame_q = '{32'h00000005};
        run_frame("t5", 0, 0, got);
        check("t5 const", got, 16'h0005);

        frame_q = '{32'h11223344, 32'hA0B0C0D0, 32'h0F0E0D0C};
        run_frame("t6 b2b", 0, 0, b2b_sum);
        for (int g = 1; g <= 3; g++) begin
            run_frame("t6 gap", g, 0, got);
            check("t6 same", got, b2b_sum);
        end

        for (int f = 0; f < 25; f++) begin
            int nb = (f % 5 == 0) ? 70 : int'($urandom_range(1, 6));
            frame_q.delete();
            for (int i = 0; i < nb; i++) frame_q.push_back($urandom);
            run_frame("rand", -1, int'($urandom_range(0, 3)), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
